// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scans four hex digits over one shared segment bus, with blanking, blink and per-digit enables.
// Latency: all outputs registered; captured data is visible BLANK_CYC cycles after upd_ack.
// Backpressure: the requester holds upd_req until upd_ack, which only fires on a frame boundary.
module seg_scan_ctrl #(
    parameter int SLOT_CYC     = 200000,
    parameter int BLANK_CYC    = 2000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_req,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_en,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  blink_en,
    output logic        upd_ack,
    output logic        frame_start,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = $clog2(SLOT_CYC);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYC - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_st_e;

    // With no blanking interval the slot starts directly in DRIVE.
    localparam slot_st_e ST_RST = (BLANK_CYC > 0) ? ST_BLANK : ST_DRIVE;

    // cyc/slot/st describe the cycle whose outputs are registered on the coming edge.
    slot_st_e      st, st_nxt;
    logic [CW-1:0] cyc, cyc_nxt;
    logic [1:0]    slot, slot_nxt;
    logic [FW-1:0] frm, frm_nxt;
    logic          blink_ph, blink_ph_nxt;
    logic          started, started_nxt;

    logic [15:0]   sh_dig, sh_dig_nxt;
    logic [3:0]    sh_dp, sh_dp_nxt;
    logic [3:0]    sh_den, sh_den_nxt;
    logic [3:0]    sh_blk, sh_blk_nxt;

    logic          cyc_wrap;
    logic          boundary;
    logic          capture;
    logic          dark;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Slot/frame counters, blink phase and frame-aligned shadow capture.
    always_comb begin
        cyc_wrap     = (cyc == CYC_LAST);
        // Cycle 0 of slot 0 after at least one full frame: the frame-boundary edge.
        boundary     = started && (cyc == '0) && (slot == 2'd0);
        capture      = boundary && upd_req;
        cyc_nxt      = cyc_wrap ? '0 : cyc + CW'(1);
        slot_nxt     = cyc_wrap ? slot + 2'd1 : slot;
        started_nxt  = started | (cyc_wrap && (slot == 2'd3));
        frm_nxt      = frm;
        blink_ph_nxt = blink_ph;
        if (boundary) begin
            if (frm == FRM_LAST) begin
                frm_nxt      = '0;
                blink_ph_nxt = ~blink_ph;
            end else begin
                frm_nxt = frm + FW'(1);
            end
        end
        sh_dig_nxt = capture ? digits   : sh_dig;
        sh_dp_nxt  = capture ? dp_en    : sh_dp;
        sh_den_nxt = capture ? digit_en : sh_den;
        sh_blk_nxt = capture ? blink_en : sh_blk;
        // Decode from the post-capture view so new data is never a frame late.
        dark       = ~sh_den_nxt[slot] | (sh_blk_nxt[slot] & blink_ph_nxt);
    end

    // BLANK/DRIVE next state and the pin values for the current cycle.
    always_comb begin
        st_nxt  = st;
        an_nxt  = 4'hF;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        case (st)
            ST_BLANK: begin
                if (int'(cyc_nxt) >= BLANK_CYC) st_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (cyc_wrap && (BLANK_CYC > 0)) st_nxt = ST_BLANK;
                // Anode stays on even for a dark digit, keeping scan duty constant.
                an_nxt = ~(4'b0001 << slot);
                if (!dark) begin
                    seg_nxt = hex7(sh_dig_nxt[{slot, 2'b00} +: 4]);
                    dp_nxt  = ~sh_dp_nxt[slot];
                end
            end
            default: st_nxt = ST_RST;
        endcase
    end

    // State, shadow and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= ST_RST;
            cyc         <= '0;
            slot        <= 2'd0;
            frm         <= '0;
            blink_ph    <= 1'b0;
            started     <= 1'b0;
            sh_dig      <= 16'h0;
            sh_dp       <= 4'h0;
            sh_den      <= 4'h0;
            sh_blk      <= 4'h0;
            an          <= 4'hF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            upd_ack     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            st          <= st_nxt;
            cyc         <= cyc_nxt;
            slot        <= slot_nxt;
            frm         <= frm_nxt;
            blink_ph    <= blink_ph_nxt;
            started     <= started_nxt;
            sh_dig      <= sh_dig_nxt;
            sh_dp       <= sh_dp_nxt;
            sh_den      <= sh_den_nxt;
            sh_blk      <= sh_blk_nxt;
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            upd_ack     <= capture;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: checks seg_scan_ctrl against a cycle-index reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bench acts as the requester, dropping upd_req after upd_ack.
module tb_seg_scan_ctrl;

    localparam int SLOT  = 10;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        upd_req = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp_en = 4'h0, digit_en = 4'h0, blink_en = 4'h0;

    logic        upd_ack, frame_start, dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        upd_ack0, frame_start0, dp0;
    logic [3:0]  an0;
    logic [6:0]  seg0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .upd_req(upd_req), .digits(digits), .dp_en(dp_en),
        .digit_en(digit_en), .blink_en(blink_en), .upd_ack(upd_ack),
        .frame_start(frame_start), .an(an), .seg(seg), .dp(dp));

    seg_scan_ctrl #(.SLOT_CYC(SLOT), .BLANK_CYC(0), .BLINK_FRAMES(BF)) dut0 (
        .clk(clk), .rst(rst), .upd_req(upd_req), .digits(digits), .dp_en(dp_en),
        .digit_en(digit_en), .blink_en(blink_en), .upd_ack(upd_ack0),
        .frame_start(frame_start0), .an(an0), .seg(seg0), .dp(dp0));

    logic [6:0] dec_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model: t is the visible cycle index since reset release.
    int          t = -1;
    logic [15:0] m_dig;
    logic [3:0]  m_den, m_dpen, m_ben;
    logic [3:0]  e_an, e_an0;
    logic [6:0]  e_seg, e_seg0;
    logic        e_dp, e_dp0, e_ack, e_fs;

    function automatic void model_out(input int blank, output logic [3:0] a,
                                      output logic [6:0] s, output logic p);
        int sl = (t % FRAME) / SLOT;
        int c  = t % SLOT;
        int f  = t / FRAME;
        bit ph = ((f / BF) % 2) == 1;
        bit dk = !m_den[sl] || (m_ben[sl] && ph);
        if (c < blank) begin
            a = 4'hF; s = 7'h7F; p = 1'b1;
        end else begin
            a = ~(4'b0001 << sl);
            s = dk ? 7'h7F : dec_tab[m_dig[4*sl +: 4]];
            p = dk ? 1'b1 : ~m_dpen[sl];
        end
    endfunction

    task automatic model_clear();
        t = -1; m_dig = 16'h0; m_den = 4'h0; m_dpen = 4'h0; m_ben = 4'h0;
    endtask

    // Advance one clock and update the model with what was driven before the edge.
    task automatic tick();
        logic        req_s = upd_req;
        logic [15:0] d_s   = digits;
        logic [3:0]  den_s = digit_en, dpe_s = dp_en, be_s = blink_en;
        @(posedge clk); #1;
        t++;
        e_fs  = (t > 0) && (t % FRAME == 0);
        e_ack = e_fs && req_s;
        if (e_ack) begin
            m_dig = d_s; m_den = den_s; m_dpen = dpe_s; m_ben = be_s;
        end
        model_out(BLANK, e_an, e_seg, e_dp);
        model_out(0, e_an0, e_seg0, e_dp0);
    endtask

    task automatic do_reset();
        rst = 1'b1; upd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        int first_fs = -1;
        rst = 1'b1; upd_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({an, seg, dp, upd_ack, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_vals got an=%b seg=%b dp=%b ack=%b fs=%b want 1111 1111111 1 0 0",
                     an, seg, dp, upd_ack, frame_start);
        end
        checks++;
        if ({an0, seg0, dp0, upd_ack0, frame_start0} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_vals0 got an=%b seg=%b dp=%b", an0, seg0, dp0);
        end
        rst = 1'b0;
        model_clear();
        repeat (3 * FRAME) begin
            tick();
            checks++;
            if ({an, seg, dp, upd_ack, frame_start} !== {e_an, e_seg, e_dp, e_ack, e_fs}) begin
                errors++;
                $display("FAIL dark t=%0d got an=%b seg=%b dp=%b ack=%b fs=%b want an=%b seg=%b dp=%b ack=%b fs=%b",
                         t, an, seg, dp, upd_ack, frame_start, e_an, e_seg, e_dp, e_ack, e_fs);
            end
            checks++;
            if ({an0, seg0, dp0} !== {e_an0, e_seg0, e_dp0}) begin
                errors++;
                $display("FAIL dark0 t=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         t, an0, seg0, dp0, e_an0, e_seg0, e_dp0);
            end
            if (frame_start === 1'b1 && first_fs < 0) first_fs = t;
        end
        checks++;
        if (first_fs !== 40) begin
            errors++;
            $display("FAIL first_frame_start got cycle %0d want 40", first_fs);
        end
    endtask

    task automatic test_update_scan();
        int ack_t = -1;
        bit fs_at_ack = 1'b0;
        do_reset();
        digits = 16'hF830; digit_en = 4'b1111; dp_en = 4'b0100; blink_en = 4'b0000;
        upd_req = 1'b1;
        for (int i = 0; i < 5 * FRAME && ack_t < 0; i++) begin
            tick();
            if (upd_ack === 1'b1) begin
                ack_t = t; fs_at_ack = frame_start;
            end
        end
        upd_req = 1'b0;
        checks++;
        if (ack_t !== 40 || fs_at_ack !== 1'b1) begin
            errors++;
            $display("FAIL upd_ack_timing got ack cycle %0d fs=%b want cycle 40 fs=1", ack_t, fs_at_ack);
        end
        while (t < 79) begin
            tick();
            checks++;
            if ({an, seg, dp, upd_ack, frame_start} !== {e_an, e_seg, e_dp, e_ack, e_fs}) begin
                errors++;
                $display("FAIL scan t=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         t, an, seg, dp, e_an, e_seg, e_dp);
            end
            if (t == 45) begin
                checks++;
                if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
                    errors++;
                    $display("FAIL digit0 got an=%b seg=%b dp=%b want 1110 1000000 1", an, seg, dp);
                end
            end
            if (t == 55) begin
                checks++;
                if ({an, seg, dp} !== {4'b1101, 7'b0110000, 1'b1}) begin
                    errors++;
                    $display("FAIL digit1 got an=%b seg=%b dp=%b want 1101 0110000 1", an, seg, dp);
                end
            end
            if (t == 65) begin
                checks++;
                if ({an, seg, dp} !== {4'b1011, 7'b0000000, 1'b0}) begin
                    errors++;
                    $display("FAIL digit2 got an=%b seg=%b dp=%b want 1011 0000000 0", an, seg, dp);
                end
            end
            if (t == 75) begin
                checks++;
                if ({an, seg, dp} !== {4'b0111, 7'b0001110, 1'b1}) begin
                    errors++;
                    $display("FAIL digit3 got an=%b seg=%b dp=%b want 0111 0001110 1", an, seg, dp);
                end
            end
        end
    endtask

    task automatic test_blank_overlap();
        int nb = 0, nb0 = 0;
        digits = 16'($urandom); digit_en = 4'($urandom_range(15, 1));
        dp_en = 4'($urandom); blink_en = 4'h0;
        upd_req = 1'b1;
        for (int i = 0; i < 2 * FRAME && upd_ack !== 1'b1; i++) tick();
        upd_req = 1'b0;
        while (t % SLOT != SLOT - 1) tick();
        repeat (16 * SLOT) begin
            tick();
            if (an === 4'hF) nb++;
            if (an0 === 4'hF) nb0++;
            checks++;
            if ($countones(~an) > 1 || $countones(~an0) > 1) begin
                errors++;
                $display("FAIL overlap t=%0d got an=%b an0=%b want at most one low bit", t, an, an0);
            end
            checks++;
            if ({an, seg, dp, an0, seg0, dp0} !== {e_an, e_seg, e_dp, e_an0, e_seg0, e_dp0}) begin
                errors++;
                $display("FAIL rand_scan t=%0d got %b/%b/%b %b/%b/%b want %b/%b/%b %b/%b/%b",
                         t, an, seg, dp, an0, seg0, dp0, e_an, e_seg, e_dp, e_an0, e_seg0, e_dp0);
            end
            if (t % SLOT == SLOT - 1) begin
                checks++;
                if (nb != BLANK || nb0 != 0) begin
                    errors++;
                    $display("FAIL blank_len t=%0d got %0d/%0d want %0d/0", t, nb, nb0, BLANK);
                end
                nb = 0; nb0 = 0;
            end
        end
    endtask

    task automatic test_tear_free();
        int acks = 0;
        while (t % FRAME != 4) tick();
        repeat (FRAME - 5) begin
            if ($urandom_range(3, 0) == 0) begin
                digits = 16'($urandom); digit_en = 4'($urandom); dp_en = 4'($urandom);
            end
            tick();
            checks++;
            if ({an, seg, dp, upd_ack} !== {e_an, e_seg, e_dp, e_ack}) begin
                errors++;
                $display("FAIL tear t=%0d got an=%b seg=%b dp=%b ack=%b want an=%b seg=%b dp=%b ack=%b",
                         t, an, seg, dp, upd_ack, e_an, e_seg, e_dp, e_ack);
            end
        end
        digits = 16'($urandom); digit_en = 4'b1111; dp_en = 4'($urandom);
        upd_req = 1'b1;
        repeat (FRAME + 1) begin
            tick();
            if (upd_ack === 1'b1) acks++;
            checks++;
            if ({an, seg, dp, upd_ack, frame_start} !== {e_an, e_seg, e_dp, e_ack, e_fs}) begin
                errors++;
                $display("FAIL boundary_req t=%0d got an=%b seg=%b dp=%b ack=%b fs=%b want %b %b %b %b %b",
                         t, an, seg, dp, upd_ack, frame_start, e_an, e_seg, e_dp, e_ack, e_fs);
            end
        end
        upd_req = 1'b0;
        checks++;
        if (acks != 2) begin
            errors++;
            $display("FAIL held_req_acks got %0d want 2", acks);
        end
    endtask

    task automatic test_blink();
        int shown [6] = '{0, 0, 0, 0, 0, 0};
        do_reset();
        digits = 16'($urandom); digit_en = 4'b1011; blink_en = 4'b0001; dp_en = 4'($urandom);
        upd_req = 1'b1;
        while (t < 6 * FRAME - 1) begin
            tick();
            if (upd_ack === 1'b1) upd_req = 1'b0;
            checks++;
            if ({an, seg, dp, upd_ack} !== {e_an, e_seg, e_dp, e_ack}) begin
                errors++;
                $display("FAIL blink t=%0d got an=%b seg=%b dp=%b ack=%b want an=%b seg=%b dp=%b ack=%b",
                         t, an, seg, dp, upd_ack, e_an, e_seg, e_dp, e_ack);
            end
            if (an === 4'b1011) begin
                checks++;
                if (seg !== 7'h7F) begin
                    errors++;
                    $display("FAIL digit2_disabled t=%0d got seg=%b want 1111111", t, seg);
                end
            end
            if (an === 4'b1110 && seg !== 7'h7F) shown[t / FRAME]++;
        end
        checks++;
        if (shown[1] != 8 || shown[2] != 0 || shown[3] != 0 || shown[4] != 8 || shown[5] != 8) begin
            errors++;
            $display("FAIL blink_frames got f1..f5=%0d,%0d,%0d,%0d,%0d want 8,0,0,8,8",
                     shown[1], shown[2], shown[3], shown[4], shown[5]);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        digits = 16'($urandom); digit_en = 4'b1111; dp_en = 4'($urandom); blink_en = 4'h0;
        upd_req = 1'b1;
        while (t < FRAME) tick();
        upd_req = 1'b0;
        while (t % FRAME != 2 * SLOT + 5) tick();
        upd_req = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({an, seg, dp, upd_ack, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got an=%b seg=%b dp=%b ack=%b fs=%b want 1111 1111111 1 0 0",
                     an, seg, dp, upd_ack, frame_start);
        end
        rst = 1'b0; upd_req = 1'b0;
        model_clear();
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if ({an, seg, dp, upd_ack, frame_start} !== {e_an, e_seg, e_dp, e_ack, e_fs}) begin
                errors++;
                $display("FAIL post_reset_dark t=%0d got an=%b seg=%b dp=%b ack=%b want an=%b seg=%b dp=%b ack=%b",
                         t, an, seg, dp, upd_ack, e_an, e_seg, e_dp, e_ack);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_update_scan();
        test_blank_overlap();
        test_tear_free();
        test_blink();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
